// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the decoder to a req/ack data-memory bus with byte lanes.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  is_load,
  input  logic [1:0]  is_store,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [2:0] LOAD_DISABLE  = 3'd0;
  localparam logic [2:0] LOAD_LB       = 3'd1;
  localparam logic [2:0] LOAD_LH       = 3'd2;
  localparam logic [2:0] LOAD_LW       = 3'd3;
  localparam logic [2:0] LOAD_LBU      = 3'd4;
  localparam logic [2:0] LOAD_LHU      = 3'd5;
  localparam logic [1:0] STORE_DISABLE = 2'd0;
  localparam logic [1:0] STORE_SB      = 2'd1;
  localparam logic [1:0] STORE_SH      = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        stall_s;
  logic        req_op_s;
  logic        misalign_s;
  logic [1:0]  size_s;
  logic [1:0]  eff_off_s;
  logic        timeout_s;

  logic        mem_req_r, mem_we_r, load_valid_r, bus_err_r, misalign_r;
  logic [31:0] mem_addr_r, mem_wdata_r, load_data_r;
  logic [3:0]  mem_be_r;
  logic [2:0]  load_op_r;
  logic [1:0]  off_r;
  logic [7:0]  cnt_r;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << off;
      SZ_HALF: lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_wdata = {4{data[7:0]}};
      SZ_HALF: lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      LOAD_LB:  extend_load = {{24{b[7]}}, b};
      LOAD_LBU: extend_load = {24'd0, b};
      LOAD_LH:  extend_load = {{16{h[15]}}, h};
      LOAD_LHU: extend_load = {16'd0, h};
      LOAD_LW:  extend_load = rdata;
      default:  extend_load = 32'd0;
    endcase
  endfunction

  assign req_op_s  = (is_load != LOAD_DISABLE) || (is_store != STORE_DISABLE);
  assign timeout_s = (cnt_r == TIMEOUT_LAST);

  // Access size from the decoder codes; a load wins if both are presented.
  always_comb begin
    size_s = SZ_WORD;
    if (is_load != LOAD_DISABLE) begin
      case (is_load)
        LOAD_LB, LOAD_LBU: size_s = SZ_BYTE;
        LOAD_LH, LOAD_LHU: size_s = SZ_HALF;
        default:           size_s = SZ_WORD;
      endcase
    end else begin
      case (is_store)
        STORE_SB: size_s = SZ_BYTE;
        STORE_SH: size_s = SZ_HALF;
        default:  size_s = SZ_WORD;
      endcase
    end
  end

  // Lane offset with bits below natural alignment dropped.
  always_comb begin
    case (size_s)
      SZ_BYTE: eff_off_s = addr[1:0];
      SZ_HALF: eff_off_s = {addr[1], 1'b0};
      default: eff_off_s = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment detection for halfword and word accesses.
  always_comb begin
    case (size_s)
      SZ_HALF: misalign_s = addr[0];
      SZ_WORD: misalign_s = (addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and stall decode.
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = req_op_s;
        if (req_op_s) begin
          state_s = misalign_s ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (mem_ack || timeout_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus request, captured operation, timeout counter and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_be_r     <= 4'd0;
      mem_wdata_r  <= 32'd0;
      load_data_r  <= 32'd0;
      load_valid_r <= 1'b0;
      bus_err_r    <= 1'b0;
      misalign_r   <= 1'b0;
      load_op_r    <= LOAD_DISABLE;
      off_r        <= 2'd0;
      cnt_r        <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          load_valid_r <= 1'b0;
          bus_err_r    <= 1'b0;
          misalign_r   <= 1'b0;
          if (req_op_s) begin
            load_op_r <= is_load;
            off_r     <= eff_off_s;
            cnt_r     <= 8'd0;
            if (misalign_s) begin
              load_data_r <= 32'd0;
              misalign_r  <= 1'b1;
            end else begin
              mem_req_r   <= 1'b1;
              mem_we_r    <= (is_load == LOAD_DISABLE);
              mem_addr_r  <= {addr[31:2], 2'b00};
              mem_be_r    <= lane_be(size_s, eff_off_s);
              mem_wdata_r <= lane_wdata(size_s, store_data);
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            if (load_op_r != LOAD_DISABLE) begin
              load_data_r  <= extend_load(load_op_r, off_r, mem_rdata);
              load_valid_r <= 1'b1;
            end
          end else if (timeout_s) begin
            mem_req_r   <= 1'b0;
            bus_err_r   <= 1'b1;
            load_data_r <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          load_valid_r <= 1'b0;
          bus_err_r    <= 1'b0;
          misalign_r   <= 1'b0;
        end
        default: begin
          mem_req_r    <= 1'b0;
          load_valid_r <= 1'b0;
          bus_err_r    <= 1'b0;
          misalign_r   <= 1'b0;
        end
      endcase
    end
  end

  assign stall      = stall_s;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;
  assign load_data  = load_data_r;
  assign load_valid = load_valid_r;
  assign bus_err    = bus_err_r;
  assign misalign   = misalign_r;

endmodule
